// File: rtl/usb_hexdump_tx.sv
// Byte-capture FIFO and ASCII hex formatter feeding the uart_tx debug serializer.
// Bytes print as uppercase two-digit hex, space-separated, with CR LF every BYTES_PER_LINE bytes.
`timescale 1ns/1ps
module usb_hexdump_tx #(
  parameter int DEPTH          = 16,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic                     clk48,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     enable,
  input  logic                     uart_busy,
  output logic                     uart_dv,
  output logic [7:0]               uart_d,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_SEP, S_CR, S_LF} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;

  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    line_cnt_q, line_cnt_d;
  logic          seen_busy_q, seen_busy_d;
  logic [2:0]    tmo_q, tmo_d;
  logic          dv_q, dv_d;
  logic [7:0]    d_q, d_d;

  logic          empty, full, pop, push, drop, char_done;
  logic [7:0]    rd_data;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign pop     = (state_q == S_IDLE) && enable && !empty && !uart_busy;
  // A full FIFO still takes the byte when the formatter frees a slot that same cycle.
  assign push    = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk48) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // A character is complete once busy has risen and fallen; if busy never rises, a short timeout releases the wait.
  assign char_done = !uart_busy && (seen_busy_q || (tmo_q == '1));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    line_cnt_d  = line_cnt_q;
    seen_busy_d = seen_busy_q;
    tmo_d       = tmo_q;
    dv_d        = 1'b0;
    d_d         = d_q;

    if (state_q != S_IDLE) begin
      if (uart_busy)    seen_busy_d = 1'b1;
      if (!seen_busy_q) tmo_d = tmo_q + 3'd1;
    end

    case (state_q)
      S_IDLE: if (pop) begin
        hold_d  = rd_data;
        d_d     = hex(rd_data[7:4]);
        dv_d    = 1'b1;
        state_d = S_HI;
      end
      S_HI: if (char_done) begin
        d_d     = hex(hold_q[3:0]);
        dv_d    = 1'b1;
        state_d = S_LO;
      end
      S_LO: if (char_done) begin
        dv_d = 1'b1;
        if (line_cnt_q == 8'(BYTES_PER_LINE - 1)) begin
          d_d     = 8'h0D;
          state_d = S_CR;
        end else begin
          d_d        = 8'h20;
          line_cnt_d = line_cnt_q + 8'd1;
          state_d    = S_SEP;
        end
      end
      S_CR: if (char_done) begin
        d_d        = 8'h0A;
        dv_d       = 1'b1;
        line_cnt_d = '0;
        state_d    = S_LF;
      end
      S_SEP, S_LF: if (char_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (dv_d) begin
      seen_busy_d = 1'b0;
      tmo_d       = '0;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      line_cnt_q  <= '0;
      seen_busy_q <= 1'b0;
      tmo_q       <= '0;
      dv_q        <= 1'b0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      line_cnt_q  <= line_cnt_d;
      seen_busy_q <= seen_busy_d;
      tmo_q       <= tmo_d;
      dv_q        <= dv_d;
      d_q         <= d_d;
    end
  end

  assign uart_dv  = dv_q;
  assign uart_d   = d_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_usb_hexdump_tx.sv
// Directed bench for usb_hexdump_tx: two instances (4 and 16 bytes per line, DEPTH 4) with uart_tx busy models.
`timescale 1ns/1ps
module tb_usb_hexdump_tx;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       enable;

  logic       busy [2] = '{1'b0, 1'b0};
  logic       dv   [2];
  logic [7:0] d    [2];
  logic [2:0] lvl  [2];
  logic       ovf  [2];

  int unsigned busy_cnt    [2] = '{0, 0};
  int unsigned rx_cnt      [2] = '{0, 0};
  int unsigned viol_busy   [2] = '{0, 0};
  int unsigned viol_consec [2] = '{0, 0};
  logic        dv_prev     [2] = '{1'b0, 1'b0};
  logic [7:0]  rx_mem [2][512];
  bit          stretch = 1'b0;

  int unsigned tests    = 0;
  int unsigned failures = 0;
  int unsigned base     [2];

  always #5 clk48 = ~clk48;

  usb_hexdump_tx #(.DEPTH(4), .BYTES_PER_LINE(4)) u_dut_a (
    .clk48(clk48), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .enable(enable), .uart_busy(busy[0]), .uart_dv(dv[0]), .uart_d(d[0]),
    .level(lvl[0]), .overflow(ovf[0]));

  usb_hexdump_tx #(.DEPTH(4), .BYTES_PER_LINE(16)) u_dut_b (
    .clk48(clk48), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .enable(enable), .uart_busy(busy[1]), .uart_dv(dv[1]), .uart_d(d[1]),
    .level(lvl[1]), .overflow(ovf[1]));

  // uart_tx stand-in: latch the character on dv, raise busy on that edge, hold it for a while.
  always @(posedge clk48) begin
    for (int g = 0; g < 2; g++) begin
      if (dv[g] && busy[g])    viol_busy[g]   <= viol_busy[g] + 1;
      if (dv[g] && dv_prev[g]) viol_consec[g] <= viol_consec[g] + 1;
      dv_prev[g] <= dv[g];
      if (busy[g]) begin
        if (busy_cnt[g] <= 1) busy[g] <= 1'b0;
        else                  busy_cnt[g] <= busy_cnt[g] - 1;
      end else if (dv[g]) begin
        rx_mem[g][rx_cnt[g] % 512] <= d[g];
        rx_cnt[g]   <= rx_cnt[g] + 1;
        busy[g]     <= 1'b1;
        busy_cnt[g] <= stretch ? $urandom_range(5000, 10) : 20;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    enable   = 1'b0;
    repeat (3) @(posedge clk48);
    @(negedge clk48) rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk48);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic end_push();
    @(negedge clk48);
    in_valid = 1'b0;
  endtask

  task automatic mark();
    base[0] = rx_cnt[0];
    base[1] = rx_cnt[1];
  endtask

  task automatic wait_chars(input int g, input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rx_cnt[g] < n && k < budget) begin
      @(posedge clk48);
      k++;
    end
    if (rx_cnt[g] < n) check("timeout_chars", rx_cnt[g], n);
  endtask

  task automatic check_stream(input string tag, input int g, input string s);
    int unsigned k = 0;
    wait_chars(g, base[g] + s.len(), s.len() * 5100 + 200);
    while (busy[g] && k < 6000) begin
      @(posedge clk48);
      k++;
    end
    repeat (50) @(posedge clk48);
    check($sformatf("%s_len", tag), rx_cnt[g] - base[g], s.len());
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s[%0d]", tag, i), rx_mem[g][(base[g] + i) % 512], s[i]);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    enable   = 1'b0;
    in_data  = '0;
    #23;
    check("rst_dv",    dv[0],  1'b0);
    check("rst_d",     d[0],   8'h00);
    check("rst_level", lvl[0], 3'd0);
    check("rst_ovf",   ovf[0], 1'b0);
    @(negedge clk48) rst_n = 1'b1;

    // single byte with edge-accurate latency
    enable = 1'b1;
    mark();
    @(negedge clk48);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk48) #1 in_valid = 1'b0;
    check("t1_dv_n",    dv[1],  1'b0);
    check("t1_level_n", lvl[1], 3'd1);
    @(posedge clk48) #1;
    check("t1_dv_n1",   dv[1],  1'b1);
    check("t1_d_n1",    d[1],   8'h41);
    check("t1_level_0", lvl[1], 3'd0);
    @(posedge clk48) #1;
    check("t1_dv_n2",   dv[1],  1'b0);
    check_stream("t1_b", 1, "A5 ");
    check_stream("t1_a", 0, "A5 ");

    // line wrap
    reset_dut();
    enable = 1'b1;
    mark();
    push(8'h00); push(8'h01); push(8'h9F); push(8'hFF); push(8'h10);
    end_push();
    check_stream("t2_a", 0, "00 01 9F FF\r\n10 ");
    check_stream("t2_b", 1, "00 01 9F FF 10 ");

    // overflow while formatter disabled
    reset_dut();
    mark();
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    end_push();
    check("t3_level", lvl[1], 3'd4);
    check("t3_ovf",   ovf[1], 1'b1);
    check("t3_ovf_a", ovf[0], 1'b1);
    @(negedge clk48) enable = 1'b1;
    check_stream("t3_b", 1, "11 12 13 14 ");
    check_stream("t3_a", 0, "11 12 13 14\r\n");
    check("t3_ovf_sticky", ovf[1], 1'b1);

    // push when full on the pop edge
    reset_dut();
    mark();
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    @(negedge clk48);
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h25;
    @(posedge clk48) #1 in_valid = 1'b0;
    check("t4_level", lvl[0], 3'd4);
    check("t4_ovf",   ovf[0], 1'b0);
    check("t4_dv",    dv[0],  1'b1);
    check_stream("t4_a", 0, "21 22 23 24\r\n25 ");
    check_stream("t4_b", 1, "21 22 23 24 25 ");

    // asynchronous reset while waiting on busy after LO
    reset_dut();
    mark();
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    end_push();
    enable = 1'b1;
    wait_chars(0, base[0] + 5, 2000);
    check("t5_pre_level", lvl[0], 3'd2);
    check("t5_pre_ovf",   ovf[0], 1'b1);
    check("t5_pre_busy",  busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dv",    dv[0],  1'b0);
    check("t5_d",     d[0],   8'h00);
    check("t5_level", lvl[0], 3'd0);
    check("t5_ovf",   ovf[0], 1'b0);
    check("t5_ovf_b", ovf[1], 1'b0);
    @(negedge clk48) rst_n = 1'b1;
    mark();
    push(8'h3C); push(8'h3D); push(8'h3E); push(8'h3F);
    end_push();
    check_stream("t5_a", 0, "3C 3D 3E 3F\r\n");
    check_stream("t5_b", 1, "3C 3D 3E 3F ");

    // long random busy periods
    reset_dut();
    stretch = 1'b1;
    enable  = 1'b1;
    mark();
    push(8'h5A); push(8'hC3); push(8'h07);
    end_push();
    check_stream("t6_a", 0, "5A C3 07 ");
    check_stream("t6_b", 1, "5A C3 07 ");
    stretch = 1'b0;

    for (int g = 0; g < 2; g++) begin
      check($sformatf("dv_while_busy_%0d", g), viol_busy[g],   0);
      check($sformatf("dv_consec_%0d", g),     viol_consec[g], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
